// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam int          INSTR_BYTES = 4;
   localparam logic [63:0] ALIGN_MASK  = ~64'(INSTR_BYTES - 1);

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: redirect input, instruction-memory channel, decode-side output.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_pc;
   logic [ADDR_W-1:0]  fetch_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, instr_ready,
      output imem_req_valid, imem_req_addr, instr_valid, instr_data,
             instr_pc, fetch_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, instr_ready,
      input  imem_req_valid, imem_req_addr, instr_valid, instr_data,
             instr_pc, fetch_pc
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is zero when empty.
module fetch_fifo #(
   parameter  int DATA_W = 96,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Flush wins over any same-cycle push or pop.
   assign do_push = push && !flush && (count != CNT_W'(DEPTH));
   assign do_pop  = pop && !flush && (count != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head_valid = (count != '0);
   assign head_data  = head_valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, PC-tagged buffer, redirect flush.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                ADDR_W     = 64,
   parameter int                INSTR_W    = 32,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_unit_if.master  bus
);
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = ADDR_W + INSTR_W;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   fetch_pc_q;
   logic [ADDR_W-1:0]   fetch_pc_nxt;
   logic [ADDR_W-1:0]   req_addr;
   logic [ADDR_W-1:0]   redirect_target;
   logic [CNT_W-1:0]    count;
   logic                has_room;
   logic                req_valid;
   logic                req_fire;
   logic                push;
   logic                pop;
   logic                head_valid;
   logic [ENTRY_W-1:0]  head_data;

   assign has_room        = (count < CNT_W'(FIFO_DEPTH));
   assign redirect_target = bus.redirect_pc & ALIGN_MASK[ADDR_W-1:0];
   assign req_fire        = req_valid && bus.imem_req_ready;
   assign pop             = head_valid && bus.instr_ready;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc_q;
      req_valid    = 1'b0;
      push         = 1'b0;
      unique case (state)
         REQ: begin
            req_valid = reset && has_room && !bus.redirect_valid;
            if (req_valid && bus.imem_req_ready) begin
               fetch_pc_nxt = fetch_pc_q + ADDR_W'(INSTR_BYTES);
               state_nxt    = WAIT;
            end
         end
         WAIT: begin
            // A redirect discards the response, arriving now or later.
            if (bus.imem_rsp_valid) begin
               push      = !bus.redirect_valid;
               state_nxt = REQ;
            end else if (bus.redirect_valid) begin
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (bus.imem_rsp_valid) state_nxt = REQ;
         end
         default: state_nxt = REQ;
      endcase
      if (bus.redirect_valid) fetch_pc_nxt = redirect_target;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= REQ;
         fetch_pc_q <= RESET_PC;
      end else begin
         state      <= state_nxt;
         fetch_pc_q <= fetch_pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) req_addr <= fetch_pc_q;
   end

   fetch_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (bus.redirect_valid),
      .push       (push),
      .push_data  ({req_addr, bus.imem_rsp_data}),
      .pop        (pop),
      .count      (count),
      .head_valid (head_valid),
      .head_data  (head_data)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.instr_valid    = head_valid;
   assign bus.instr_pc       = head_data[ENTRY_W-1:INSTR_W];
   assign bus.instr_data     = head_data[INSTR_W-1:0];
   assign bus.fetch_pc       = fetch_pc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a variable-latency instruction memory model.
module tb_instr_fetch_unit;
   localparam int          ADDR_W     = 64;
   localparam int          INSTR_W    = 32;
   localparam int          FIFO_DEPTH = 4;
   localparam logic [63:0] RESET_PC   = 64'd0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();

   instr_fetch_unit #(
      .ADDR_W     (ADDR_W),
      .INSTR_W    (INSTR_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_pops   = 0;
   int          n_rsp    = 0;
   int          lat      = 1;
   bit          const_data = 1'b1;
   bit          hs = 1'b0;
   logic [63:0] hs_addr = '0;
   logic [95:0] sb[$];
   logic [63:0] req_log[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return const_data ? 32'h13 : (a[31:0] ^ 32'hA5A5_0013);
   endfunction

   function automatic logic [63:0] log_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   // Transaction monitor: sampled mid-cycle, reflects what the next rising edge commits.
   always @(negedge clk) begin
      logic [95:0] e;
      if (!reset) begin
         sb.delete();
         hs = 1'b0;
      end else begin
         hs      = bus.imem_req_valid && bus.imem_req_ready;
         hs_addr = bus.imem_req_addr;
         if (hs) req_log.push_back(hs_addr);
         if (bus.redirect_valid) begin
            sb.delete();
         end else begin
            if (bus.instr_valid && bus.instr_ready) begin
               n_pops++;
               if (sb.size() == 0) begin
                  chk("sb_underflow", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("instr_pc", bus.instr_pc, e[95:32]);
                  chk("instr_data", 64'(bus.instr_data), 64'(e[31:0]));
               end
            end
            if (hs) sb.push_back({hs_addr, mem_word(hs_addr)});
         end
      end
   end

   // Instruction memory: responds once, lat cycles after the accepted request.
   initial begin
      bit          pend;
      int          cnt;
      logic [63:0] paddr;
      pend = 1'b0;
      cnt  = 0;
      paddr = '0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.imem_rsp_valid = 1'b0;
         if (!reset) begin
            pend = 1'b0;
         end else begin
            if (hs) begin
               pend  = 1'b1;
               cnt   = lat - 1;
               paddr = hs_addr;
            end
            if (pend) begin
               if (cnt == 0) begin
                  bus.imem_rsp_valid = 1'b1;
                  bus.imem_rsp_data  = mem_word(paddr);
                  pend = 1'b0;
                  n_rsp++;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.instr_ready    = 1'b0;
      bus.imem_req_ready = 1'b1;
      tick(2);
      req_log.delete();
      reset = 1'b1;
   endtask

   task automatic wait_reqs(input int n, input int budget, input string tag);
      int k = 0;
      while (req_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 64'(req_log.size() >= n), 64'd1);
   endtask

   task automatic drain(input string tag);
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b1;
      tick(20);
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      chk({tag, "_valid_low"}, 64'(bus.instr_valid), 64'd0);
      bus.instr_ready    = 1'b0;
      bus.imem_req_ready = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int k;
      int rsp_mark;
      bit found;

      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.instr_ready    = 1'b0;
      bus.imem_req_ready = 1'b1;
      #12;
      chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("rst_fetch_pc", bus.fetch_pc, RESET_PC);
      chk("rst_instr_data", 64'(bus.instr_data), 64'd0);
      chk("rst_instr_pc", bus.instr_pc, 64'd0);

      // Sequential fetch, 1-cycle memory returning 0x13.
      const_data = 1'b1;
      lat = 1;
      do_reset();
      bus.instr_ready = 1'b1;
      p0 = n_pops;
      wait_reqs(3, 40, "t1_reqs");
      chk("t1_req0", log_at(0), 64'h0);
      chk("t1_req1", log_at(1), 64'h4);
      chk("t1_req2", log_at(2), 64'h8);
      k = 0;
      while (n_pops < p0 + 3 && k < 40) begin tick(); k++; end
      chk("t1_pops", 64'(n_pops >= p0 + 3), 64'd1);
      drain("t1");

      // Full buffer stalls requests; one pop frees a slot.
      const_data = 1'b0;
      lat = 1;
      do_reset();
      tick(30);
      chk("t2_req_count", 64'(req_log.size()), 64'd4);
      chk("t2_req3", log_at(3), 64'hC);
      chk("t2_req_valid_full", 64'(bus.imem_req_valid), 64'd0);
      p0 = n_pops;
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      tick(10);
      chk("t2_one_pop", 64'(n_pops - p0), 64'd1);
      chk("t2_req_count2", 64'(req_log.size()), 64'd5);
      chk("t2_req4", log_at(4), 64'h10);
      drain("t2");

      // Redirect while waiting; late response must be dropped.
      lat = 4;
      do_reset();
      wait_reqs(3, 60, "t3_reqs");
      chk("t3_req2", log_at(2), 64'h8);
      chk("t3_buf_before", 64'(bus.instr_valid), 64'd1);
      rsp_mark = n_rsp;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h100;
      tick();
      bus.redirect_valid = 1'b0;
      chk("t3_flushed", 64'(bus.instr_valid), 64'd0);
      chk("t3_fetch_pc", bus.fetch_pc, 64'h100);
      wait_reqs(4, 40, "t3_req_after");
      chk("t3_req3", log_at(3), 64'h100);
      chk("t3_rsp_before_req", 64'(n_rsp > rsp_mark), 64'd1);
      drain("t3");

      // Redirect coincident with the response, unaligned target.
      lat = 3;
      do_reset();
      bus.instr_ready = 1'b1;
      found = 1'b0;
      k = 0;
      while (!found && k < 20) begin
         @(posedge clk);
         #2;
         found = bus.imem_rsp_valid;
         k++;
      end
      chk("t4_rsp_seen", 64'(found), 64'd1);
      req_log.delete();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h203;
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
      chk("t4_fetch_pc", bus.fetch_pc, 64'h200);
      chk("t4_empty", 64'(bus.instr_valid), 64'd0);
      wait_reqs(1, 20, "t4_req");
      chk("t4_req0", log_at(0), 64'h200);
      drain("t4");

      // Fetch PC wraps at the top of the address space.
      lat = 1;
      do_reset();
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      req_log.delete();
      tick();
      chk("t5_wrap_pc", bus.fetch_pc, 64'h0);
      wait_reqs(2, 20, "t5_reqs");
      chk("t5_req0", log_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t5_req1", log_at(1), 64'h0);
      drain("t5");

      // Asynchronous reset mid-WAIT with two buffered entries.
      lat = 5;
      do_reset();
      wait_reqs(3, 80, "t6_reqs");
      chk("t6_buf_valid", 64'(bus.instr_valid), 64'd1);
      chk("t6_head_pc", bus.instr_pc, 64'h0);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(bus.instr_valid), 64'd0);
      chk("t6_rst_data", 64'(bus.instr_data), 64'd0);
      chk("t6_rst_pc", bus.instr_pc, 64'd0);
      chk("t6_rst_req", 64'(bus.imem_req_valid), 64'd0);
      chk("t6_rst_fetch_pc", bus.fetch_pc, RESET_PC);
      req_log.delete();
      tick(2);
      reset = 1'b1;
      wait_reqs(1, 20, "t6_req_after");
      chk("t6_req0", log_at(0), RESET_PC);
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
